// File: rtl/pru_cmd_queue.sv
// Bus-mapped draw-command FIFO feeding the PRU draw engine.
// Two bus writes assemble a 44-bit command; a dispatcher strobes each one into the PRU when idle.
module pru_cmd_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    input  logic        busy,
    output logic [1:0]  color,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic [9:0]  width,
    output logic [8:0]  height_radius,
    output logic [1:0]  shape_select,
    output logic        subtract,
    output logic        color_load,
    output logic        start,
    output logic        q_empty,
    output logic        q_full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    // Field order mirrors {WORD0[24:0], WORD1[18:0]} so a commit is a plain concatenation.
    typedef struct packed {
        logic       color_load;
        logic       subtract;
        logic [1:0] shape;
        logic [9:0] col;
        logic [8:0] row;
        logic [1:0] color;
        logic [8:0] hr;
        logic [9:0] width;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state_q;
    logic [TW-1:0]   tmr_q;
    cmd_t            cmd_q;
    logic            start_q;
    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, full_q;
    logic [24:0]     stage_q;
    logic            ack_q;
    logic [31:0]     rdata_q;

    logic            hit, wr_req, rd_req, acc_wr, push, pop, flush;
    logic [1:0]      off;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:25]};

    // A request is ignored during its own ack cycle so a held request is taken once.
    assign hit    = bus_addr[31:4] == BASE_ADDR[31:4];
    assign off    = bus_addr[3:2];
    assign wr_req = bus_write && hit && !ack_q;
    assign rd_req = bus_read && !bus_write && hit && !ack_q;
    assign acc_wr = wr_req && !(off == 2'd1 && full_q);
    assign flush  = acc_wr && off == 2'd3 && bus_wdata[0];
    assign push   = acc_wr && off == 2'd1 && !flush;
    assign pop    = state_q == IDLE && !empty_q && !busy && !flush;

    assign status = {16'd0, 8'(count_q), 5'd0, state_q != IDLE, full_q, empty_q};

    always_comb begin
        count_d = count_q;
        if (flush)              count_d = '0;
        else if (push && !pop)  count_d = count_q + 1'b1;
        else if (pop && !push)  count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            stage_q <= '0;
        end else begin
            ack_q   <= acc_wr || rd_req;
            rdata_q <= (rd_req && off == 2'd2) ? status : '0;
            if (acc_wr && off == 2'd0) stage_q <= bus_wdata[24:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= count_d == '0;
            full_q  <= count_d == CW'(DEPTH);
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= cmd_t'({stage_q, bus_wdata[18:0]});
    end

    // Timer starts at 1 so IDLE is re-entered BUSY_TIMEOUT cycles after the start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cmd_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    cmd_q   <= mem_q[rptr_q];
                    start_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    tmr_q   <= TW'(1);
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy)                                   state_q <= WAIT_DONE;
                    else if (tmr_q >= TW'(BUSY_TIMEOUT - 1))    state_q <= IDLE;
                    else                                        tmr_q   <= tmr_q + 1'b1;
                end
                WAIT_DONE: if (!busy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_ack       = ack_q;
    assign bus_rdata     = rdata_q;
    assign color         = cmd_q.color;
    assign row           = cmd_q.row;
    assign col           = cmd_q.col;
    assign width         = cmd_q.width;
    assign height_radius = cmd_q.hr;
    assign shape_select  = cmd_q.shape;
    assign subtract      = cmd_q.subtract;
    assign color_load    = cmd_q.color_load;
    assign start         = start_q;
    assign q_empty       = empty_q;
    assign q_full        = full_q;
endmodule

// File: tb/tb_pru_cmd_queue.sv
// Bench for pru_cmd_queue: scoreboard of committed commands checked at every start pulse,
// plus per-scenario timing and status checks.
module tb_pru_cmd_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BT    = 4;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic        bus_write = 1'b0, bus_read = 1'b0;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        busy_man = 1'b0, busy_auto = 1'b0, auto_en = 1'b0;
    logic [1:0]  color, shape_select;
    logic [8:0]  row, height_radius;
    logic [9:0]  col, width;
    logic        subtract, color_load, start, q_empty, q_full;

    assign busy = busy_man | busy_auto;

    pru_cmd_queue #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write(bus_write), .bus_read(bus_read), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy), .color(color), .row(row), .col(col), .width(width),
        .height_radius(height_radius), .shape_select(shape_select), .subtract(subtract),
        .color_load(color_load), .start(start), .q_empty(q_empty), .q_full(q_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [43:0] exp_q[$];
    int          start_cycs[$];
    int          n_tests = 0, n_fail = 0;

    function automatic logic [43:0] mk(input logic [31:0] w0, input logic [31:0] w1);
        return {w0[24:0], w1[18:0]};
    endfunction

    // Scoreboard: every start must present the oldest committed, not-yet-flushed command.
    always @(negedge clk) begin : mon
        logic [43:0] got, want;
        if (rst_n && start) begin
            got = {color_load, subtract, shape_select, col, row, color, height_radius, width};
            start_cycs.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_order: got unexpected command %h, required no start", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL start_order: got %h required %h", got, want);
                end
            end
        end
    end

    // PRU model: busy for 10 cycles after each start while enabled.
    always begin : resp
        @(negedge clk);
        if (auto_en && start) begin
            @(posedge clk); #1 busy_auto = 1'b1;
            repeat (10) @(posedge clk);
            #1 busy_auto = 1'b0;
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input int lim,
                          output logic acked, output int ack_cyc);
        bus_addr = a; bus_wdata = d; bus_write = 1'b1; acked = 1'b0; ack_cyc = -1;
        for (int i = 0; i < lim && !acked; i++) begin
            @(negedge clk);
            if (bus_ack) begin acked = 1'b1; ack_cyc = cyc; end
        end
        @(posedge clk); #1 bus_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input int lim,
                          output logic acked, output logic [31:0] d);
        bus_addr = a; bus_read = 1'b1; acked = 1'b0; d = '0;
        for (int i = 0; i < lim && !acked; i++) begin
            @(negedge clk);
            if (bus_ack) begin acked = 1'b1; d = bus_rdata; end
        end
        @(posedge clk); #1 bus_read = 1'b0;
    endtask

    task automatic push_cmd(input logic [31:0] w0, input logic [31:0] w1, output int ack_cyc);
        logic ok; int c;
        bus_wr(BASE, w0, 8, ok, c);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL word0_ack: got no ack, required ack"); end
        exp_q.push_back(mk(w0, w1));
        bus_wr(BASE + 32'h4, w1, 8, ok, ack_cyc);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL word1_ack: got no ack, required ack");
            void'(exp_q.pop_back());
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s: got %0d commands pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        logic ok; logic [31:0] d; int c;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus_ack, bus_rdata, color, row, col, width, height_radius, shape_select,
             subtract, color_load, start, q_full} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        n_tests++;
        if (q_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", q_empty); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_wr(BASE + 32'h10, 32'h1, 4, ok, c);
        n_tests++;
        if (ok) begin n_fail++; $display("FAIL out_of_window: got ack, required none"); end
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (!ok || d !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h (ack %b) required 00000001", d, ok); end
        bus_rd(BASE, 4, ok, d);
        n_tests++;
        if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL read_word0: got %h (ack %b) required 0 with ack", d, ok); end
        bus_wr(BASE + 32'h8, 32'hFFFF_FFFF, 4, ok, c);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL write_status_ack: got no ack, required ack"); end
    endtask

    task automatic test_basic;
        int ac; logic ok; logic [31:0] d;
        start_cycs.delete();
        push_cmd(32'h0000_1C05, 32'h0000_2814, ac);
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if (start_cycs.size() != 1 || start_cycs[0] != ac + 1) begin
            n_fail++; $display("FAIL push_to_start: got %0d starts (first at %0d), required 1 at %0d",
                               start_cycs.size(), (start_cycs.size() > 0) ? start_cycs[0] : -1, ac + 1);
        end
        // 0x1C05 has bit 10 set, which is the top bit of the row field.
        n_tests++;
        if ({color, row, col, width, height_radius} !== {2'd1, 9'h101, 10'd3, 10'd20, 9'd10}) begin
            n_fail++; $display("FAIL basic_fields: got c%0d r%0d col%0d w%0d h%0d required c1 r257 col3 w20 h10",
                               color, row, col, width, height_radius);
        end
        repeat (BT + 2) @(posedge clk); #1;
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL basic_status: got %h required 00000001", d); end
    endtask

    task automatic test_full;
        int ac; logic ok, saw; logic [31:0] d, w1;
        busy_man = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < int'(DEPTH); i++) push_cmd($urandom & 32'h01FF_FFFF, $urandom & 32'h7FFFF, ac);
        @(negedge clk);
        n_tests++;
        if (q_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b required 1", q_full); end
        @(posedge clk); #1;
        bus_wr(BASE, 32'h0155_AAAA, 4, ok, ac);
        w1 = 32'h0004_5678;
        exp_q.push_back(mk(32'h0155_AAAA, w1));
        start_cycs.delete();
        bus_addr = BASE + 32'h4; bus_wdata = w1; bus_write = 1'b1;
        saw = 1'b0;
        repeat (5) begin @(negedge clk); if (bus_ack) saw = 1'b1; end
        n_tests++;
        if (saw) begin n_fail++; $display("FAIL full_stall: got ack while full, required none"); end
        @(posedge clk); #1 busy_man = 1'b0;
        @(posedge clk); #1 busy_man = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6 && !saw; i++) begin @(negedge clk); if (bus_ack) saw = 1'b1; end
        @(posedge clk); #1 bus_write = 1'b0;
        n_tests++;
        if (!saw) begin n_fail++; $display("FAIL stall_release: got no ack, required ack after pop"); end
        n_tests++;
        if (start_cycs.size() != 1) begin n_fail++; $display("FAIL one_pop: got %0d starts required 1", start_cycs.size()); end
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d[15:8] !== 8'(DEPTH) || d[1] !== 1'b1 || q_full !== 1'b1) begin
            n_fail++; $display("FAIL full_count: got count %0d full %b required %0d full 1", d[15:8], q_full, DEPTH);
        end
        busy_man = 1'b0;
        wait_drain("full_drain");
        repeat (BT + 2) @(posedge clk); #1;
        n_tests++;
        if (q_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b required 1", q_empty); end
    endtask

    task automatic test_order;
        int ac;
        busy_man = 1'b1;
        auto_en  = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_cmd(32'h0100_0000 | (i * 32'h111), 32'h100 + i, ac);
        start_cycs.delete();
        busy_man = 1'b0;
        wait_drain("order_drain");
        for (int i = 0; i < 40 && (busy_auto || !q_empty); i++) @(posedge clk);
        repeat (4) @(posedge clk); #1;
        auto_en = 1'b0;
        n_tests++;
        if (start_cycs.size() != 3) begin n_fail++; $display("FAIL order_count: got %0d starts required 3", start_cycs.size()); end
        for (int i = 1; i < start_cycs.size(); i++) begin
            n_tests++;
            if (start_cycs[i] - start_cycs[i-1] < 12) begin
                n_fail++; $display("FAIL order_spacing: got %0d cycles required >= 12", start_cycs[i] - start_cycs[i-1]);
            end
        end
    endtask

    task automatic test_timeout;
        int ac; logic ok; logic [31:0] d;
        busy_man = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_cmd(32'h0020_0000 + i, 32'h0000_0400 + i, ac);
        start_cycs.delete();
        busy_man = 1'b0;
        wait_drain("timeout_drain");
        repeat (BT + 2) @(posedge clk); #1;
        n_tests++;
        if (start_cycs.size() != 3) begin n_fail++; $display("FAIL timeout_count: got %0d starts required 3", start_cycs.size()); end
        for (int i = 1; i < start_cycs.size(); i++) begin
            n_tests++;
            if (start_cycs[i] - start_cycs[i-1] != int'(BT) + 1) begin
                n_fail++; $display("FAIL timeout_spacing: got %0d cycles required %0d", start_cycs[i] - start_cycs[i-1], BT + 1);
            end
        end
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL timeout_idle: got status %h required 00000001", d); end
    endtask

    task automatic test_flush;
        int ac; logic ok; logic [31:0] d;
        busy_man = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_cmd(32'h00AB_0000 + i, 32'h0000_0300 + i, ac);
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d[15:8] !== 8'd4) begin n_fail++; $display("FAIL preflush_count: got %0d required 4", d[15:8]); end
        bus_wr(BASE + 32'hC, 32'h1, 4, ok, ac);
        exp_q.delete();
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d !== 32'h1 || q_empty !== 1'b1) begin
            n_fail++; $display("FAIL flush_status: got %h empty %b required 00000001 empty 1", d, q_empty);
        end
        start_cycs.delete();
        busy_man = 1'b0;
        repeat (20) @(posedge clk); #1;
        n_tests++;
        if (start_cycs.size() != 0) begin n_fail++; $display("FAIL flush_nostart: got %0d starts required 0", start_cycs.size()); end
    endtask

    task automatic test_reset_mid;
        int ac; logic ok, seen, saw; logic [31:0] d;
        push_cmd(32'h0000_0777, 32'h0000_0123, ac);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (start) seen = 1'b1; end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL midreset_start: got no start, required one"); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (start !== 1'b0 || q_empty !== 1'b1 || bus_ack !== 1'b0) begin
            n_fail++; $display("FAIL midreset_async: got start %b empty %b ack %b required 0 1 0", start, q_empty, bus_ack);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (4) begin @(negedge clk); if (bus_ack || start) saw = 1'b1; end
        n_tests++;
        if (saw) begin n_fail++; $display("FAIL midreset_quiet: got ack or start after release, required none"); end
        @(posedge clk); #1;
        bus_rd(BASE + 32'h8, 4, ok, d);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL midreset_status: got %h required 00000001", d); end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_order();
        test_timeout();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
